// File: rtl/centronics_receiver.sv
// ============================================================================
// centronics_receiver: peripheral end of a Centronics printer port; BUSY/ACK
// handshake, byte FIFO for a downstream consumer, status line drive.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module centronics_receiver #(
   parameter int FIFO_AW    = 4,
   parameter int STB_MIN    = 4,
   parameter int ACK_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         lpt_data,
   input  logic               lpt_strobe_n,
   input  logic               lpt_init_n,
   input  logic               lpt_af_n,
   input  logic               lpt_selout_n,
   output logic               lpt_ack_n,
   output logic               lpt_busy,
   output logic               lpt_pe,
   output logic               lpt_sel,
   output logic               lpt_err_n,
   input  logic               cfg_pe,
   input  logic               cfg_sel,
   input  logic               cfg_err,
   input  logic               rd_en,
   output logic [7:0]         rd_data,
   output logic               rd_valid,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               host_autofeed,
   output logic               host_selected,
   output logic               init_pulse
);

   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int CNT_MAX = (STB_MIN > ACK_CYCLES) ? STB_MIN : ACK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FILTER    = 3'd1;
   localparam logic [2:0] S_CAPTURE   = 3'd2;
   localparam logic [2:0] S_WAIT_HIGH = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;

   logic [7:0]         r_data_s1, r_data_s2;
   logic               r_stb_s1, r_stb_s2;
   logic               r_init_s1, r_init_s2, r_init_d;
   logic               r_af_s1, r_af_s2;
   logic               r_sel_s1, r_sel_s2;
   logic               r_pe, r_sel, r_err_n;

   logic [2:0]         r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt, w_cnt_nxt;

   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr, r_rptr, w_rptr_nxt;
   logic [FIFO_AW:0]   r_level, w_level_nxt;
   logic [7:0]         r_rd_data;
   logic               r_overflow;

   logic               w_init_fall, w_full, w_empty, w_pop, w_push, w_capture;
   logic               w_busy, w_ack_n;

   // Synchronizers idle at the inactive (high) level so reset looks like an idle host
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_s1 <= '0;
         r_data_s2 <= '0;
         r_stb_s1  <= 1'b1;
         r_stb_s2  <= 1'b1;
         r_init_s1 <= 1'b1;
         r_init_s2 <= 1'b1;
         r_init_d  <= 1'b1;
         r_af_s1   <= 1'b1;
         r_af_s2   <= 1'b1;
         r_sel_s1  <= 1'b1;
         r_sel_s2  <= 1'b1;
         r_pe      <= 1'b0;
         r_sel     <= 1'b0;
         r_err_n   <= 1'b1;
      end else begin
         r_data_s1 <= lpt_data;
         r_data_s2 <= r_data_s1;
         r_stb_s1  <= lpt_strobe_n;
         r_stb_s2  <= r_stb_s1;
         r_init_s1 <= lpt_init_n;
         r_init_s2 <= r_init_s1;
         r_init_d  <= r_init_s2;
         r_af_s1   <= lpt_af_n;
         r_af_s2   <= r_af_s1;
         r_sel_s1  <= lpt_selout_n;
         r_sel_s2  <= r_sel_s1;
         r_pe      <= cfg_pe;
         r_sel     <= cfg_sel;
         r_err_n   <= ~cfg_err;
      end
   end

   assign w_init_fall = r_init_d & ~r_init_s2;
   assign w_full      = (r_level == (FIFO_AW+1)'(DEPTH));
   assign w_empty     = (r_level == '0);
   assign w_pop       = rd_en & ~w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // INIT held low pins the FSM in IDLE, which also discards a byte in CAPTURE
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!r_init_s2) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_stb_s2) begin
                  w_state_nxt = S_FILTER;
                  w_cnt_nxt   = CW'(1);
               end
            end
            S_FILTER: begin
               if (r_stb_s2) begin
                  w_state_nxt = S_IDLE;
               end else if (r_cnt >= CW'(STB_MIN - 1)) begin
                  w_state_nxt = S_CAPTURE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_CAPTURE: w_state_nxt = S_WAIT_HIGH;
            S_WAIT_HIGH: begin
               if (r_stb_s2) begin
                  w_state_nxt = S_ACK;
                  w_cnt_nxt   = '0;
               end
            end
            S_ACK: begin
               if (r_cnt >= CW'(ACK_CYCLES - 1)) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy    = 1'b1;
      w_ack_n   = 1'b1;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE, S_FILTER: w_busy = w_full;
         S_CAPTURE:        w_capture = r_init_s2;
         S_ACK:            w_ack_n = ~r_init_s2;
         default:          w_busy = 1'b1;
      endcase
      if (!r_init_s2) w_busy = 1'b1;
   end

   assign w_push     = w_capture & (~w_full | w_pop);
   assign w_rptr_nxt = w_pop ? r_rptr + FIFO_AW'(1) : r_rptr;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + (FIFO_AW+1)'(1);
         2'b01:   w_level_nxt = r_level - (FIFO_AW+1)'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= r_data_s2;
   end

   // rd_data tracks the next head, bypassing a byte written into the head slot
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_rd_data  <= '0;
         r_overflow <= 1'b0;
      end else if (w_init_fall) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
         r_rptr  <= w_rptr_nxt;
         r_level <= w_level_nxt;
         if (w_level_nxt != '0) begin
            r_rd_data <= (w_push && (r_wptr == w_rptr_nxt)) ? r_data_s2 : r_mem[w_rptr_nxt];
         end
         if (w_capture && !w_push) r_overflow <= 1'b1;
      end
   end

   assign lpt_ack_n     = w_ack_n;
   assign lpt_busy      = w_busy;
   assign lpt_pe        = r_pe;
   assign lpt_sel       = r_sel;
   assign lpt_err_n     = r_err_n;
   assign rd_data       = r_rd_data;
   assign rd_valid      = ~w_empty;
   assign fifo_level    = r_level;
   assign overflow      = r_overflow;
   assign host_autofeed = ~r_af_s2;
   assign host_selected = ~r_sel_s2;
   assign init_pulse    = w_init_fall;

endmodule

`default_nettype wire

// File: tb/tb_centronics_receiver.sv
// ============================================================================
// tb_centronics_receiver: directed vectors for the Centronics receiver.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_centronics_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] lpt_data;
   logic       lpt_strobe_n, lpt_init_n, lpt_af_n, lpt_selout_n;
   logic       lpt_ack_n, lpt_busy, lpt_pe, lpt_sel, lpt_err_n;
   logic       cfg_pe, cfg_sel, cfg_err, rd_en;
   logic [7:0] rd_data;
   logic       rd_valid, overflow, host_autofeed, host_selected, init_pulse;
   logic [4:0] fifo_level;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   centronics_receiver #(.FIFO_AW(4), .STB_MIN(4), .ACK_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .lpt_data(lpt_data), .lpt_strobe_n(lpt_strobe_n),
      .lpt_init_n(lpt_init_n), .lpt_af_n(lpt_af_n), .lpt_selout_n(lpt_selout_n),
      .lpt_ack_n(lpt_ack_n), .lpt_busy(lpt_busy), .lpt_pe(lpt_pe), .lpt_sel(lpt_sel),
      .lpt_err_n(lpt_err_n), .cfg_pe(cfg_pe), .cfg_sel(cfg_sel), .cfg_err(cfg_err),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
      .overflow(overflow), .host_autofeed(host_autofeed), .host_selected(host_selected),
      .init_pulse(init_pulse)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      lpt_data     = d;
      lpt_strobe_n = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      lpt_strobe_n = 1'b1;
      for (int k = 0; k < 12; k++) tick();
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      int t_busy, t_valid, t_ack, t_rise, n_ack, n_pulse;
      logic busy_rise, busy_ack, ack_at_pulse, saw_ack, glitch_seen;

      rst = 1'b1; lpt_data = 8'h00; lpt_strobe_n = 1'b1; lpt_init_n = 1'b1;
      lpt_af_n = 1'b1; lpt_selout_n = 1'b1; cfg_pe = 1'b0; cfg_sel = 1'b0;
      cfg_err = 1'b0; rd_en = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check_val("rst_ack_n", lpt_ack_n, 1);
      check_val("rst_busy", lpt_busy, 0);
      check_val("rst_err_n", lpt_err_n, 1);
      check_val("rst_valid", rd_valid, 0);
      check_val("rst_level", fifo_level, 0);
      check_val("rst_rd_data", rd_data, 0);
      rst = 1'b0;
      tick();

      // single byte with full handshake timing
      t_busy = 0; t_valid = 0; t_ack = 0; t_rise = 0; n_ack = 0;
      busy_rise = 1'b1; busy_ack = 1'b1;
      lpt_data = 8'hA5; lpt_strobe_n = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (lpt_busy && t_busy == 0) t_busy = k;
         if (rd_valid && t_valid == 0) t_valid = k;
         if (!lpt_ack_n) begin
            n_ack++;
            if (t_ack == 0) t_ack = k;
            if (!lpt_busy) busy_ack = 1'b0;
         end else if (t_ack != 0 && t_rise == 0) begin
            t_rise = k;
            busy_rise = lpt_busy;
         end
         if (k == 10) lpt_strobe_n = 1'b1;
      end
      check_val("busy_rise_cycle", t_busy, 6);
      check_val("valid_cycle", t_valid, 7);
      check_val("byte_a5", rd_data, 8'hA5);
      check_val("ack_first_cycle", t_ack, 13);
      check_val("ack_width", n_ack, 8);
      check_val("ack_rise_cycle", t_rise, 21);
      check_val("busy_in_ack", busy_ack, 1);
      check_val("busy_at_ack_rise", busy_rise, 0);
      pop_one();
      check_val("pop_a5_level", fifo_level, 0);

      // glitch shorter than the filter
      glitch_seen = 1'b0;
      lpt_data = 8'h3C; lpt_strobe_n = 1'b0;
      tick(); tick();
      lpt_strobe_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (lpt_busy || !lpt_ack_n || rd_valid) glitch_seen = 1'b1;
      end
      check_val("glitch_ignored", glitch_seen, 0);

      // fill, overflow, drain
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      check_val("fill_level", fifo_level, 16);
      check_val("fill_busy", lpt_busy, 1);
      check_val("fill_no_ovf", overflow, 0);
      send_byte(8'hEE);
      check_val("ovf_set", overflow, 1);
      check_val("ovf_level", fifo_level, 16);
      check_val("head_00", rd_data, 8'h00);
      pop_one();
      check_val("pop_level15", fifo_level, 15);
      check_val("busy_after_pop", lpt_busy, 0);
      for (int i = 1; i < 16; i++) begin
         check_val("drain_order", rd_data, 32'(i));
         pop_one();
      end
      check_val("drain_empty", rd_valid, 0);
      check_val("ovf_sticky", overflow, 1);
      check_val("rd_data_hold", rd_data, 8'h0F);

      rst = 1'b1; tick(); rst = 1'b0; tick();
      check_val("ovf_cleared_rst", overflow, 0);

      // full FIFO with a pop in the CAPTURE cycle
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
      lpt_data = 8'h77; lpt_strobe_n = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
      check_val("simul_level", fifo_level, 16);
      check_val("simul_no_ovf", overflow, 0);
      check_val("simul_head", rd_data, 8'h11);
      lpt_strobe_n = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      for (int i = 0; i < 15; i++) pop_one();
      check_val("simul_last", rd_data, 8'h77);
      check_val("simul_last_level", fifo_level, 1);

      rst = 1'b1; tick(); rst = 1'b0; tick();

      // INIT during the ACK phase of the 5th byte
      for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i));
      lpt_data = 8'h54; lpt_strobe_n = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      lpt_strobe_n = 1'b1;
      saw_ack = 1'b0;
      for (int k = 0; k < 10 && !saw_ack; k++) begin
         tick();
         if (!lpt_ack_n) saw_ack = 1'b1;
      end
      check_val("init_ack_reached", saw_ack, 1);
      check_val("init_pre_level", fifo_level, 5);
      lpt_init_n = 1'b0;
      n_pulse = 0; ack_at_pulse = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (init_pulse) begin
            n_pulse++;
            ack_at_pulse = lpt_ack_n;
         end
      end
      check_val("init_pulse_count", n_pulse, 1);
      check_val("init_ack_n", ack_at_pulse, 1);
      check_val("init_level", fifo_level, 0);
      check_val("init_busy_held", lpt_busy, 1);
      lpt_data = 8'h99; lpt_strobe_n = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      lpt_strobe_n = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check_val("init_strobe_ignored", fifo_level, 0);
      check_val("init_ack_idle", lpt_ack_n, 1);
      lpt_init_n = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check_val("init_release_busy", lpt_busy, 0);

      // status, host lines, reset mid-WAIT_HIGH
      cfg_err = 1'b1; cfg_pe = 1'b1; cfg_sel = 1'b1;
      check_val("status_before_edge", lpt_err_n, 1);
      tick();
      check_val("status_err_n", lpt_err_n, 0);
      check_val("status_pe", lpt_pe, 1);
      check_val("status_sel", lpt_sel, 1);
      lpt_af_n = 1'b0; lpt_selout_n = 1'b0;
      tick(); tick();
      check_val("host_autofeed", host_autofeed, 1);
      check_val("host_selected", host_selected, 1);
      lpt_data = 8'h66; lpt_strobe_n = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check_val("wh_busy", lpt_busy, 1);
      check_val("wh_level", fifo_level, 1);
      rst = 1'b1; lpt_strobe_n = 1'b1;
      tick();
      check_val("rst2_ack_n", lpt_ack_n, 1);
      check_val("rst2_busy", lpt_busy, 0);
      check_val("rst2_pe", lpt_pe, 0);
      check_val("rst2_sel", lpt_sel, 0);
      check_val("rst2_err_n", lpt_err_n, 1);
      check_val("rst2_level", fifo_level, 0);
      check_val("rst2_rd_data", rd_data, 0);
      check_val("rst2_af", host_autofeed, 0);
      check_val("rst2_selected", host_selected, 0);
      check_val("rst2_init_pulse", init_pulse, 0);
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
